sorted_stream_reader: RTL and testbench
=======================================

// Module: sorted_stream_reader
// PURPOSE
//  Reader/drain end of the systolic sorting-cell chain. Cells accept inserts; this block empties the sorted result.
//  On command it pulses array_shift_up/array_enable so each head word moves toward cell 0.
//  It captures each head word and presents the words in ascending order on a valid/ready output stream.
//  It marks the final word with out_last and pulses done.
// PARAMETERS
//  DATA_WIDTH  8    width of one sorted element (matches cell width)
//  NUM_CELLS   16   number of cells in the chain; maximum element count
//  COUNT_W     $clog2(NUM_CELLS+1)  width of element counters (derived, do not override)
// PORTS
//  clk             in   1           single clock; all logic on posedge
//  reset           in   1           synchronous, active-low reset
//  drain_start     in   1           1-cycle request to drain; sampled in IDLE only
//  elem_count      in   COUNT_W     number of occupied cells; sampled with drain_start
//  head_cell_data  in   DATA_WIDTH  cell_data of cell 0 (head of chain)
//  array_shift_up  out  1           chain shifts one place toward head at next edge
//  array_enable    out  1           chain enable; identical to array_shift_up
//  busy            out  1           high in any state other than IDLE
//  out_valid       out  1           out_data/out_last valid
//  out_ready       in   1           consumer accepts when out_valid&&out_ready
//  out_data        out  DATA_WIDTH  sorted element, ascending order
//  out_last        out  1           marks final element of this drain
//  done            out  1           1-cycle pulse when drain is complete
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, remaining=0, FIFO emptied.
//   All outputs 0. Reset wins over every other input, including mid-drain.
//  FSM: IDLE -> STREAM on drain_start; STREAM -> FIN when remaining==0 and FIFO empty; FIN -> IDLE always.
//  In IDLE, drain_start loads remaining <= min(elem_count, NUM_CELLS).
//   drain_start is ignored outside IDLE.
//  take = (state==STREAM) && (remaining!=0) && (fifo_cnt<2 || pop); pop = out_valid && out_ready.
//  On take: push {head_cell_data, remaining==1} into FIFO and decrement remaining.
//   array_shift_up=array_enable=take, combinationally, in the same cycle.
//  The chain updates at the edge. head_cell_data is the next element in the following cycle,
//   so back-to-back takes are legal.
//  Output stage is a 2-entry FIFO: out_valid = fifo_cnt!=0; out_data/out_last come from the FIFO head register.
//  Latency: drain_start at cycle T -> first take at T+1 -> out_valid at T+2.
//   Sustains 1 word/cycle while out_ready stays high.
//  Backpressure: at most 2 words are captured but not yet accepted.
//   No shift_up while FIFO is full and there is no pop.
//   out_data/out_last stay stable while out_valid && !out_ready.
//  Simultaneous push and pop are allowed at any FIFO occupancy; the count is unchanged.
//  elem_count==0: STREAM -> FIN at T+1 with no take; done at T+2; out_valid never asserts.
//  done is high for exactly 1 cycle, in FIN, which follows acceptance of the out_last word.
//  busy = state!=IDLE.
//  Total array_shift_up pulses per drain equal min(elem_count, NUM_CELLS), exactly.
// STRUCTURE
//  sort_pkg (shared with sorting cells):
//   - DATA_WIDTH default
//   - typedef enum {IDLE, STREAM, FIN} drain_state_t
//   - typedef struct {data, last} sort_word_t
//  Sub-module sort_out_fifo: 2-entry FIFO of sort_word_t with push/pop/count and sync active-low reset.
//  Top contains: FSM, remaining counter, take logic, instance of sort_out_fifo.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles mid-stream -> busy, out_valid, done, array_shift_up, out_last all 0.
//  2 Drain of 4: elem_count=4, head model supplies 3,7,9,12, out_ready=1.
//    -> beats 3,7,9,12 on cycles T+2..T+5; out_last on 12 only; done at T+6; exactly 4 shift_up pulses.
//  3 Backpressure: as in 2, with out_ready=0 for cycles T+2..T+7.
//    -> only 2 shift_up pulses before release; out_data=3 held stable; full order 3,7,9,12 preserved.
//  4 Empty drain: elem_count=0 -> no out_valid; no shift_up; done pulses at T+2; busy low at T+3.
//  5 Reset mid-drain: assert reset after 2 beats accepted.
//    -> IDLE next cycle, FIFO empty. A new drain_start with elem_count=2 then streams normally.
//  6 Clamp/ignore: elem_count=20 (NUM_CELLS=16) -> 16 beats; a drain_start pulsed during STREAM has no effect.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types for the sorting-cell chain and its drain-side reader.
package sort_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FIN
    } drain_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } sort_word_t;

endpackage

// File: rtl/sort_out_fifo.sv
// Two-entry output FIFO holding captured sorted words; head register drives the stream.
module sort_out_fifo
    import sort_pkg::*;
#(
    parameter type word_t = sort_word_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  word_t      push_word,
    input  logic       pop,
    output word_t      head_word,
    output logic [1:0] count
);

    word_t head_q;
    word_t tail_q;
    logic  pop_ok;
    logic  push_ok;

    assign pop_ok    = pop && (count != 2'd0);
    assign push_ok   = push && ((count != 2'd2) || pop_ok);
    assign head_word = head_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) head_q <= push_word;
                    else               tail_q <= push_word;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // With one entry the new word replaces the departing head directly.
                    if (count == 2'd1) begin
                        head_q <= push_word;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sorted_stream_reader.sv
// Drains the sorted cell chain head-first and streams the words out in ascending order.
module sorted_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CELLS  = 16,
    parameter int COUNT_W    = $clog2(NUM_CELLS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  drain_start,
    input  logic [COUNT_W-1:0]    elem_count,
    input  logic [DATA_WIDTH-1:0] head_cell_data,
    output logic                  array_shift_up,
    output logic                  array_enable,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    import sort_pkg::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } stream_word_t;

    drain_state_t       state;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] load_count;
    logic [1:0]         fifo_cnt;
    stream_word_t       head_word;
    stream_word_t       push_word;
    logic               pop;
    logic               take;
    logic               drained;

    assign pop  = out_valid && out_ready;
    // Gated by reset so the chain never moves during a reset cycle.
    assign take = reset && (state == STREAM) && (remaining != '0)
                  && ((fifo_cnt < 2'd2) || pop);

    assign array_shift_up = take;
    assign array_enable   = take;

    assign load_count = (elem_count > COUNT_W'(NUM_CELLS)) ? COUNT_W'(NUM_CELLS) : elem_count;
    assign push_word  = '{data: head_cell_data, last: (remaining == COUNT_W'(1))};

    // FIN is entered in the cycle after the final word is accepted.
    assign drained = (remaining == '0)
                     && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = head_word.data;
    assign out_last  = head_word.last;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            if (take) remaining <= remaining - COUNT_W'(1);
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        state     <= STREAM;
                        remaining <= load_count;
                    end
                end
                STREAM:  if (drained) state <= FIN;
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    sort_out_fifo #(
        .word_t(stream_word_t)
    ) u_out_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (take),
        .push_word(push_word),
        .pop      (pop),
        .head_word(head_word),
        .count    (fifo_cnt)
    );

endmodule

// File: tb/tb_sorted_stream_reader.sv
// Directed bench: chain model feeds the head word, a word-level model checks every cycle.
module tb_sorted_stream_reader;

    localparam int DW = 8;
    localparam int NC = 16;
    localparam int CW = 5;
    localparam int LOGN = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          drain_start;
    logic [CW-1:0] elem_count;
    logic [DW-1:0] head_cell_data;
    logic          array_shift_up;
    logic          array_enable;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;

    sorted_stream_reader #(
        .DATA_WIDTH(DW),
        .NUM_CELLS (NC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .drain_start   (drain_start),
        .elem_count    (elem_count),
        .head_cell_data(head_cell_data),
        .array_shift_up(array_shift_up),
        .array_enable  (array_enable),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Environment: the cell chain, head first.
    int chain[$];

    // Per-cycle and per-beat logs for the directed expectations.
    logic busy_at [LOGN];
    logic done_at [LOGN];
    logic shift_at[LOGN];
    logic valid_at[LOGN];
    int   data_at [LOGN];
    int   beat_cyc[$];
    int   beat_dat[$];
    int   beat_lst[$];
    int   shift_cnt;

    task automatic clear_logs();
        beat_cyc.delete();
        beat_dat.delete();
        beat_lst.delete();
        shift_cnt = 0;
    endtask

    task automatic load_chain(input int vals[$]);
        chain = vals;
        head_cell_data = DW'(chain[0]);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_drain(input int n, output int t);
        drain_start = 1'b1;
        elem_count  = CW'(n);
        t = cyc;
        step(1);
        drain_start = 1'b0;
    endtask

    // Word-level model: phase 0 idle, 1 streaming, 2 finishing.
    int   ph = 0;
    int   total = 0;
    int   captured = 0;
    int   accepted = 0;
    int   exp_q[$];
    logic prev_rst_low = 1'b1;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;

    initial begin
        int   c;
        int   e;
        logic pop;
        logic exp_sh;
        logic sh;
        @(posedge clk);
        forever begin
            @(negedge clk);
            c = cyc;
            if (c < LOGN) begin
                busy_at[c]  = busy;
                done_at[c]  = done;
                shift_at[c] = array_shift_up;
                valid_at[c] = out_valid;
                data_at[c]  = int'(out_data);
            end
            pop = out_valid && out_ready && reset;

            if (prev_rst_low) begin
                chk("rst_busy", busy, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_done", done, 0);
                chk("rst_shift", array_shift_up, 0);
                chk("rst_last", out_last, 0);
                chk("rst_data", out_data, 0);
            end
            chk("enable_is_shift", array_enable, array_shift_up);
            chk("busy", busy, ph != 0);
            chk("done", done, ph == 2);
            chk("valid", out_valid, captured > accepted);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            exp_sh = reset && (ph == 1) && (captured < total)
                     && (((captured - accepted) < 2) || pop);
            chk("shift", array_shift_up, exp_sh);

            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("beat_extra", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e);
                    chk("beat_last", out_last, exp_q.size() == 0);
                end
                beat_cyc.push_back(c);
                beat_dat.push_back(int'(out_data));
                beat_lst.push_back(int'(out_last));
            end
            if (array_shift_up) shift_cnt++;

            if (!reset) begin
                ph = 0;
                total = 0;
                captured = 0;
                accepted = 0;
                exp_q.delete();
            end else begin
                if (pop) accepted++;
                if (exp_sh) captured++;
                case (ph)
                    0: if (drain_start) begin
                        ph = 1;
                        total = (int'(elem_count) > NC) ? NC : int'(elem_count);
                        captured = 0;
                        accepted = 0;
                        exp_q.delete();
                        for (int i = 0; i < total; i++)
                            exp_q.push_back(i < chain.size() ? chain[i] : 0);
                    end
                    1: if (accepted == total) ph = 2;
                    default: ph = 0;
                endcase
            end
            prev_rst_low = !reset;
            prev_stall   = out_valid && !out_ready && reset;
            prev_data    = out_data;
            prev_last    = out_last;
            sh           = array_shift_up;

            @(posedge clk);
            #1;
            if (sh && chain.size() != 0) void'(chain.pop_front());
            head_cell_data = (chain.size() != 0) ? DW'(chain[0]) : '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int e4[4] = '{3, 7, 9, 12};
    int t;
    int r;
    int cnt;

    initial begin
        reset = 1'b0;
        drain_start = 1'b0;
        elem_count = '0;
        out_ready = 1'b1;
        head_cell_data = '0;
        step(3);
        reset = 1'b1;
        step(2);

        // Reset held 3 cycles in the middle of a stalled drain.
        load_chain('{1, 2, 3, 4, 99});
        clear_logs();
        out_ready = 1'b0;
        start_drain(4, t);
        step(2);
        reset = 1'b0;
        r = cyc;
        step(3);
        reset = 1'b1;
        step(2);
        for (int k = 1; k <= 3; k++) begin
            chk("t1_busy", busy_at[r + k], 0);
            chk("t1_valid", valid_at[r + k], 0);
            chk("t1_shift", shift_at[r + k], 0);
            chk("t1_done", done_at[r + k], 0);
        end
        chk("t1_busy_before", busy_at[r], 1);

        // Plain drain of four.
        load_chain('{3, 7, 9, 12, 99, 99});
        clear_logs();
        out_ready = 1'b1;
        start_drain(4, t);
        step(8);
        chk("t2_nbeats", beat_dat.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < beat_dat.size()) begin
                chk("t2_data", beat_dat[i], e4[i]);
                chk("t2_cycle", beat_cyc[i], t + 2 + i);
                chk("t2_last", beat_lst[i], i == 3);
            end
        end
        chk("t2_first_take", shift_at[t + 1], 1);
        chk("t2_done_early", done_at[t + 5], 0);
        chk("t2_done", done_at[t + 6], 1);
        chk("t2_done_late", done_at[t + 7], 0);
        chk("t2_shifts", shift_cnt, 4);

        // Backpressure from T+2 through T+7.
        load_chain('{3, 7, 9, 12, 99, 99});
        clear_logs();
        out_ready = 1'b0;
        start_drain(4, t);
        step(7);
        out_ready = 1'b1;
        step(7);
        cnt = 0;
        for (int k = 0; k <= 7; k++) cnt += int'(shift_at[t + k]);
        chk("t3_shifts_stalled", cnt, 2);
        chk("t3_held_valid", valid_at[t + 7], 1);
        chk("t3_held_data", data_at[t + 7], 3);
        chk("t3_held_data_mid", data_at[t + 4], 3);
        chk("t3_nbeats", beat_dat.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < beat_dat.size()) begin
                chk("t3_data", beat_dat[i], e4[i]);
                chk("t3_cycle", beat_cyc[i], t + 8 + i);
            end
        end
        chk("t3_done", done_at[t + 12], 1);
        chk("t3_shifts", shift_cnt, 4);

        // Empty drain.
        load_chain('{50, 51});
        clear_logs();
        start_drain(0, t);
        step(4);
        chk("t4_done_t1", done_at[t + 1], 0);
        chk("t4_done", done_at[t + 2], 1);
        chk("t4_busy_t2", busy_at[t + 2], 1);
        chk("t4_busy_t3", busy_at[t + 3], 0);
        cnt = 0;
        for (int k = 0; k <= 3; k++) cnt += int'(valid_at[t + k]);
        chk("t4_no_valid", cnt, 0);
        chk("t4_shifts", shift_cnt, 0);

        // Reset after two accepted beats, then a fresh drain of two.
        load_chain('{20, 21, 22, 23, 99});
        clear_logs();
        out_ready = 1'b1;
        start_drain(4, t);
        step(3);
        reset = 1'b0;
        out_ready = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        chk("t5_beats_before", beat_dat.size(), 2);
        chk("t5_idle_busy", busy_at[t + 5], 0);
        chk("t5_idle_valid", valid_at[t + 5], 0);
        load_chain('{5, 6, 99});
        clear_logs();
        out_ready = 1'b1;
        start_drain(2, t);
        step(6);
        chk("t5_nbeats", beat_dat.size(), 2);
        if (beat_dat.size() == 2) begin
            chk("t5_data0", beat_dat[0], 5);
            chk("t5_data1", beat_dat[1], 6);
            chk("t5_cycle0", beat_cyc[0], t + 2);
            chk("t5_last1", beat_lst[1], 1);
        end
        chk("t5_done", done_at[t + 4], 1);
        chk("t5_shifts", shift_cnt, 2);

        // Clamp to NUM_CELLS, with a drain_start pulsed while streaming.
        begin
            int v[$];
            for (int i = 0; i < 22; i++) v.push_back(3 * i + 1);
            load_chain(v);
        end
        clear_logs();
        start_drain(20, t);
        step(4);
        drain_start = 1'b1;
        elem_count = CW'(3);
        step(1);
        drain_start = 1'b0;
        step(16);
        chk("t6_nbeats", beat_dat.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < beat_dat.size()) begin
                chk("t6_data", beat_dat[i], 3 * i + 1);
                chk("t6_cycle", beat_cyc[i], t + 2 + i);
            end
        end
        chk("t6_shifts", shift_cnt, 16);
        chk("t6_done", done_at[t + 18], 1);
        chk("t6_idle", busy_at[t + 19], 0);
        chk("t6_no_restart", busy_at[t + 20], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
